hc595_rx: RTL and testbench
===========================

// Module: hc595_rx
// PURPOSE
//  Receive side of the 74HC595 LED serial bus: oversamples shcp/stcp/ds[] driven by the
//  595 LED transmitter and rebuilds the parallel LED word exactly as the 595 chain would
//  latch it. Used for on-board loopback checking of the local-dimming LED driver and as
//  a bus monitor feeding status/debug logic. Runs in the system clock domain.
// PARAMETERS
//  NCH          6      number of parallel data lines (ds[NCH-1:0]), one 595 per line
//  BITS         8      bits per line per frame (595 depth)
//  SYNC_STAGES  2      synchronizer flops on every bus input (>=2)
//  TIMEOUT      1024   clk cycles without a shcp rise before the bit counter resyncs
// PORTS
//  clk          in   1           system clock; must be >=4x shcp rate
//  rst          in   1           synchronous reset, active-low
//  shcp         in   1           shift clock from bus (async)
//  stcp         in   1           storage/latch clock from bus (async)
//  ds           in   NCH         serial data lines (async)
//  led_q        out  NCH*BITS    latched word; line c at led_q[c*BITS +: BITS]
//  frame_valid  out  1           1-clk pulse when led_q updated
//  frame_err    out  1           sticky: a latch saw bit count != BITS (see CONFIGURATION)
//  err_clr      in   1           1-clk pulse clears frame_err
//  link_up      out  1           1 while shcp rises seen within TIMEOUT
// BEHAVIOUR
//  - Reset (rst==0 at posedge clk): sync flops, shift regs, led_q, bit_cnt, timer,
//    frame_valid, frame_err, link_up all -> 0; FSM -> IDLE. Reset mid-frame discards it.
//  - Inputs pass SYNC_STAGES flops, then one extra flop for edge detect. Rise = prev 0,
//    cur 1. Input-to-edge latency SYNC_STAGES+1 clks.
//  - shcp rise: per line sreg_c <= {sreg_c[BITS-2:0], ds_sync[c]} (ds sampled from the
//    same synchronized stage as shcp); first bit shifted ends at MSB after BITS shifts.
//    bit_cnt increments, saturating at 2^$clog2(BITS+1)-1. timer <= 0.
//  - stcp rise: led_q <= concatenated sreg values; frame_valid pulses the next clk;
//    bit_cnt <= 0. sreg is NOT cleared (matches 595).
//  - Simultaneous shcp and stcp rise in one clk: latch takes sreg BEFORE this shift; the
//    shift still occurs and bit_cnt becomes 1 (not 0).
//  - FSM: IDLE -(shcp rise)-> SHIFT; SHIFT -(stcp rise)-> IDLE after latch;
//    SHIFT -(timer==TIMEOUT-1)-> IDLE with bit_cnt <= 0, sreg kept, no latch.
//    stcp rise in IDLE: latch anyway (bit_cnt 0 counts as error if checked).
//  - timer counts clks since last shcp rise, saturates at TIMEOUT-1; link_up=1 iff
//    timer<TIMEOUT-1 and at least one shcp rise since reset.
//  - err_clr and a new error in the same clk: error wins (frame_err stays 1).
//  - Pulses narrower than 2 clks on any input are not guaranteed to be seen.
// CONFIGURATION
//  HC595_RX_FRAME_CHK_EN defined: at every stcp rise, bit_cnt != BITS sets frame_err
//    (sticky until err_clr); led_q still updates.
//  Not defined: bit_cnt compare logic removed; frame_err tied 0; err_clr ignored.
// TESTING
//  1 Reset: rst=0 2 clks with bus toggling -> led_q=0, frame_valid=0, link_up=0, frame_err=0.
//  2 NCH=6,BITS=8: shift 8 bits per line, line c = 8'hA5^c, MSB first, then stcp ->
//    one frame_valid pulse, led_q[c*8+:8]=8'hA5^c, frame_err=0.
//  3 CHK_EN: 7 shcp rises then stcp -> frame_err=1, led_q updated; err_clr -> frame_err=0.
//  4 shcp and stcp rise in same sync cycle after 8 shifts of 8'h3C on line 0 ->
//    led_q[7:0]=8'h3C, then 7 more shifts+stcp -> frame_err=0 (count 8).
//  5 Stop shcp mid-frame after 4 bits for TIMEOUT clks -> link_up=0, bit_cnt=0; next full
//    8-bit frame latches correctly, link_up=1.
//  6 rst=0 for 1 clk after 5 bits, then full frame of 8'hFF -> led_q line=8'hFF, no err.

Source files
------------

// File: rtl/hc595_rx.sv
// hc595_rx: receive side of the 74HC595 LED serial bus.
// Oversamples shcp/stcp/ds[] in the system clock domain and rebuilds the
// parallel LED word exactly as a chain of 595s would latch it.
// Optional feature macro: HC595_RX_FRAME_CHK_EN
//   defined     -> frame_err flags any latch whose bit count differs from BITS
//   not defined -> frame_err tied low, err_clr ignored
module hc595_rx #(
  parameter int NCH         = 6,
  parameter int BITS        = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  shcp,
  input  logic                  stcp,
  input  logic [NCH-1:0]        ds,
  output logic [NCH*BITS-1:0]   led_q,
  output logic                  frame_valid,
  output logic                  frame_err,
  input  logic                  err_clr,
  output logic                  link_up
);

  // Synchronizer word layout: {stcp, shcp, ds[NCH-1:0]}
  localparam int SW       = NCH + 2;
  localparam int SHCP_BIT = NCH;
  localparam int STCP_BIT = NCH + 1;

  localparam int CW = $clog2(BITS + 1);
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_FULL = CW'(BITS);
  localparam logic [TW-1:0] TMR_MAX  = TW'(TIMEOUT - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [SW-1:0]        sync_q [SYNC_STAGES];
  logic [SW-1:0]        sync_d [SYNC_STAGES];
  logic                 shcp_prev_q, shcp_prev_d;
  logic                 stcp_prev_q, stcp_prev_d;
  logic [NCH*BITS-1:0]  sreg_q, sreg_d;
  logic [NCH*BITS-1:0]  led_word_q, led_word_d;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic                 seen_q, seen_d;
  logic                 frame_valid_q, frame_valid_d;
  logic [0:0]           state_q, state_d;

  logic [SW-1:0]        bus_cur;
  logic                 shcp_rise;
  logic                 stcp_rise;
  logic [NCH*BITS-1:0]  sreg_shifted;

  assign bus_cur   = sync_q[SYNC_STAGES-1];
  assign shcp_rise = bus_cur[SHCP_BIT] & ~shcp_prev_q;
  assign stcp_rise = bus_cur[STCP_BIT] & ~stcp_prev_q;

  // Synchronizer chain: stage 0 samples the pins, later stages follow
  always_comb begin
    sync_d[0] = {stcp, shcp, ds};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Edge detect flops hold the previous synchronized level of the clocks
  always_comb begin
    shcp_prev_d = bus_cur[SHCP_BIT];
    stcp_prev_d = bus_cur[STCP_BIT];
  end

  // Every line shifts its synchronized data bit in at the LSB
  always_comb begin
    sreg_shifted = sreg_q;
    for (int c = 0; c < NCH; c++) begin
      sreg_shifted[c*BITS +: BITS] = {sreg_q[c*BITS +: BITS-1], bus_cur[c]};
    end
  end

  // Frame tracking: shift, latch, bit count, idle timer and FSM
  always_comb begin
    sreg_d        = sreg_q;
    led_word_d    = led_word_q;
    bit_cnt_d     = bit_cnt_q;
    timer_d       = timer_q;
    seen_d        = seen_q | shcp_rise;
    frame_valid_d = 1'b0;
    state_d       = state_q;

    if (shcp_rise) begin
      timer_d = '0;
    end else if (timer_q != TMR_MAX) begin
      timer_d = timer_q + TW'(1);
    end

    // The latch sees the register contents from before any same-cycle shift
    if (stcp_rise) begin
      led_word_d    = sreg_q;
      frame_valid_d = 1'b1;
      bit_cnt_d     = '0;
      state_d       = ST_IDLE;
    end

    if (shcp_rise) begin
      sreg_d  = sreg_shifted;
      state_d = ST_SHIFT;
      if (stcp_rise) begin
        bit_cnt_d = CW'(1);
      end else if (bit_cnt_q != CNT_MAX) begin
        bit_cnt_d = bit_cnt_q + CW'(1);
      end
    end else if (!stcp_rise && state_q == ST_SHIFT && timer_q == TMR_MAX) begin
      // Bus went quiet mid-frame: resync the count, keep the shift contents
      bit_cnt_d = '0;
      state_d   = ST_IDLE;
    end
  end

  // Synchronizer and edge-detect registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      shcp_prev_q <= 1'b0;
      stcp_prev_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      shcp_prev_q <= shcp_prev_d;
      stcp_prev_q <= stcp_prev_d;
    end
  end

  // Frame state registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      sreg_q        <= '0;
      led_word_q    <= '0;
      bit_cnt_q     <= '0;
      timer_q       <= '0;
      seen_q        <= 1'b0;
      frame_valid_q <= 1'b0;
      state_q       <= ST_IDLE;
    end else begin
      sreg_q        <= sreg_d;
      led_word_q    <= led_word_d;
      bit_cnt_q     <= bit_cnt_d;
      timer_q       <= timer_d;
      seen_q        <= seen_d;
      frame_valid_q <= frame_valid_d;
      state_q       <= state_d;
    end
  end

  assign led_q       = led_word_q;
  assign frame_valid = frame_valid_q;
  assign link_up     = seen_q && (timer_q != TMR_MAX);

`ifdef HC595_RX_FRAME_CHK_EN
  logic frame_err_q, frame_err_d;

  // Sticky length error; a new error outranks a same-cycle clear
  always_comb begin
    frame_err_d = frame_err_q;
    if (err_clr) begin
      frame_err_d = 1'b0;
    end
    if (stcp_rise && bit_cnt_q != CNT_FULL) begin
      frame_err_d = 1'b1;
    end
  end

  // Error flag register
  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
    end
  end

  assign frame_err = frame_err_q;
`else
  logic unused_err_clr;
  logic [CW-1:0] unused_cnt_full;

  assign unused_err_clr  = err_clr;
  assign unused_cnt_full = CNT_FULL;
  assign frame_err       = 1'b0;
`endif

endmodule

// File: tb/tb_hc595_rx.sv
// Self-checking bench for hc595_rx: table-driven frames, hand-written
// corner sequences and randomized frames against a bit-history model.
module tb_hc595_rx;

  localparam int NCH     = 6;
  localparam int BITS    = 8;
  localparam int SYNC    = 2;
  localparam int TIMEOUT = 64;
  localparam int H       = 3;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 shcp = 1'b0;
  logic                 stcp = 1'b0;
  logic [NCH-1:0]       ds = '0;
  logic                 err_clr = 1'b0;
  logic [NCH*BITS-1:0]  led_q;
  logic                 frame_valid;
  logic                 frame_err;
  logic                 link_up;

  int n_chk  = 0;
  int n_pass = 0;
  int fv_cnt = 0;
  logic [NCH*BITS-1:0] cap_led = '0;

  // Reference model: history of shifted words, count since last latch
  logic [NCH-1:0] hist[$];
  int   cnt_m;
  logic err_m;

  typedef struct {
    logic [7:0]          base;
    logic [NCH*BITS-1:0] exp_led;
    logic                exp_err;
  } vec_t;
  vec_t tbl[5];

  hc595_rx #(.NCH(NCH), .BITS(BITS), .SYNC_STAGES(SYNC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .shcp(shcp), .stcp(stcp), .ds(ds),
    .led_q(led_q), .frame_valid(frame_valid), .frame_err(frame_err),
    .err_clr(err_clr), .link_up(link_up)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid === 1'b1) begin
      fv_cnt  = fv_cnt + 1;
      cap_led = led_q;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [NCH*BITS-1:0] model_led();
    logic [NCH*BITS-1:0] r;
    int idx;
    r = '0;
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < BITS; i++) begin
        idx = hist.size() - 1 - i;
        if (idx >= 0) r[c*BITS + i] = hist[idx][c];
      end
    return r;
  endfunction

  task automatic model_reset();
    hist.delete();
    cnt_m = 0;
    err_m = 1'b0;
  endtask

  task automatic model_shift(input logic [NCH-1:0] d);
    hist.push_back(d);
    if (hist.size() > 16) void'(hist.pop_front());
    if (cnt_m < 15) cnt_m++;
  endtask

  task automatic model_latch();
`ifdef HC595_RX_FRAME_CHK_EN
    if (cnt_m != BITS) err_m = 1'b1;
`endif
    cnt_m = 0;
  endtask

  task automatic shift_bit(input logic [NCH-1:0] d);
    ds = d;
    clks(H);
    shcp = 1'b1;
    model_shift(d);
    clks(H);
    shcp = 1'b0;
  endtask

  task automatic shift_byte(input logic [7:0] base);
    logic [7:0] v;
    logic [NCH-1:0] d;
    for (int b = BITS - 1; b >= 0; b--) begin
      for (int c = 0; c < NCH; c++) begin
        v = base ^ 8'(c);
        d[c] = v[b];
      end
      shift_bit(d);
    end
  endtask

  // Latch (optionally with a simultaneous shift) and check pulse, word, error
  task automatic latch_chk(input string nm, input bit both, input logic [NCH-1:0] d,
                           output logic [NCH*BITS-1:0] got);
    int base;
    logic [NCH*BITS-1:0] exp;
    base = fv_cnt;
    exp  = model_led();
    model_latch();
    if (both) begin
      ds = d;
      clks(H);
      shcp = 1'b1;
      stcp = 1'b1;
      model_shift(d);
      clks(H);
      shcp = 1'b0;
      stcp = 1'b0;
    end else begin
      stcp = 1'b1;
      clks(H);
      stcp = 1'b0;
    end
    clks(H + 2);
    got = cap_led;
    chk({nm, ".pulses"}, 64'(fv_cnt - base), 64'd1);
    chk({nm, ".led"}, 64'(cap_led), 64'(exp));
    chk({nm, ".err"}, 64'(frame_err), 64'(err_m));
  endtask

  task automatic pulse_clr(input string nm);
    err_clr = 1'b1;
    clks(1);
    err_clr = 1'b0;
    err_m = 1'b0;
    clks(1);
    chk(nm, 64'(frame_err), 64'(err_m));
  endtask

  initial begin
    logic [NCH*BITS-1:0] got;
    int n;

    for (int i = 0; i < 5; i++) begin
      tbl[i].exp_err = 1'b0;
    end
    tbl[0].base = 8'hA5; tbl[1].base = 8'h3C; tbl[2].base = 8'h00;
    tbl[3].base = 8'hFF; tbl[4].base = 8'h5A;
    for (int i = 0; i < 5; i++)
      for (int c = 0; c < NCH; c++)
        tbl[i].exp_led[c*BITS +: BITS] = tbl[i].base ^ 8'(c);

    // 1: reset with the bus toggling
    rst = 1'b0; shcp = 1'b1; ds = 6'h2A;
    clks(1);
    shcp = 1'b0; stcp = 1'b1; ds = 6'h15;
    clks(1);
    shcp = 1'b0; stcp = 1'b0; ds = '0; rst = 1'b1;
    model_reset();
    clks(2);
    chk("rst.led", 64'(led_q), 64'd0);
    chk("rst.fv", 64'(frame_valid), 64'd0);
    chk("rst.link", 64'(link_up), 64'd0);
    chk("rst.err", 64'(frame_err), 64'd0);
    chk("rst.fvcnt", 64'(fv_cnt), 64'd0);

    // 2: table-driven full frames
    for (int i = 0; i < 5; i++) begin
      shift_byte(tbl[i].base);
      latch_chk($sformatf("tbl%0d", i), 1'b0, '0, got);
      chk($sformatf("tbl%0d.vec", i), 64'(got), 64'(tbl[i].exp_led));
      chk($sformatf("tbl%0d.verr", i), 64'(frame_err), 64'(tbl[i].exp_err));
      chk($sformatf("tbl%0d.link", i), 64'(link_up), 64'd1);
    end

    // 3: short frame (7 bits) then clear
    for (int b = 0; b < 7; b++) shift_bit(6'(b * 9 + 1));
    latch_chk("short", 1'b0, '0, got);
    pulse_clr("short.clr");

    // 4: simultaneous shift and latch after 8 bits of 3C on line 0
    for (int b = 7; b >= 0; b--) shift_bit({5'b0, 1'(8'h3C >> b)});
    latch_chk("simul", 1'b1, 6'h01, got);
    chk("simul.line0", 64'(got[7:0]), 64'h3C);
    for (int b = 0; b < 7; b++) shift_bit(6'(b + 3));
    latch_chk("simul.after", 1'b0, '0, got);

    // 5: bus stalls mid-frame past the timeout
    for (int b = 0; b < 4; b++) shift_bit(6'h3F);
    clks(TIMEOUT - 20);
    chk("tmo.link_before", 64'(link_up), 64'd1);
    clks(30);
    chk("tmo.link_after", 64'(link_up), 64'd0);
    cnt_m = 0;
    shift_byte(8'h96);
    latch_chk("tmo.frame", 1'b0, '0, got);
    chk("tmo.vec", 64'(got[15:8]), 64'(8'h96 ^ 8'd1));
    chk("tmo.link_up", 64'(link_up), 64'd1);

    // 6: one-clock reset mid-frame, then a full frame of FF
    for (int b = 0; b < 5; b++) shift_bit(6'h2A);
    clks(H);
    rst = 1'b0;
    clks(1);
    rst = 1'b1;
    model_reset();
    clks(1);
    chk("rst6.led", 64'(led_q), 64'd0);
    chk("rst6.link", 64'(link_up), 64'd0);
    for (int b = 0; b < 8; b++) shift_bit(6'h3F);
    latch_chk("rst6.frame", 1'b0, '0, got);
    chk("rst6.ff", 64'(got), 64'hFFFF_FFFF_FFFF);

    // Randomized frames against the model
    for (int f = 0; f < 40; f++) begin
      n = ($urandom % 4 == 0) ? int'($urandom_range(0, 10)) : 8;
      for (int b = 0; b < n; b++) shift_bit(6'($urandom));
      clks($urandom_range(0, 5));
      latch_chk($sformatf("rnd%0d", f), ($urandom % 5 == 0), 6'($urandom), got);
      if ($urandom % 4 == 0) pulse_clr($sformatf("rnd%0d.clr", f));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
